// File: rtl/axis_iter_div_if.sv
// axis_iter_div_if: operand/result stream bundle for the iterative divider.
// slave modport is the divider's view; master modport is the EX-stage initiator's view.
interface axis_iter_div_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0]   s_axis_dividend_tdata;
  logic               s_axis_dividend_tvalid;
  logic               s_axis_dividend_tready;
  logic [WIDTH-1:0]   s_axis_divisor_tdata;
  logic               s_axis_divisor_tvalid;
  logic               s_axis_divisor_tready;
  logic [2*WIDTH-1:0] m_axis_dout_tdata;
  logic               m_axis_dout_tvalid;

  modport slave (
    input  s_axis_dividend_tdata, s_axis_dividend_tvalid,
    output s_axis_dividend_tready,
    input  s_axis_divisor_tdata, s_axis_divisor_tvalid,
    output s_axis_divisor_tready,
    output m_axis_dout_tdata, m_axis_dout_tvalid
  );

  modport master (
    output s_axis_dividend_tdata, s_axis_dividend_tvalid,
    input  s_axis_dividend_tready,
    output s_axis_divisor_tdata, s_axis_divisor_tvalid,
    input  s_axis_divisor_tready,
    input  m_axis_dout_tdata, m_axis_dout_tvalid
  );
endinterface

// File: rtl/axis_iter_div.sv
// axis_iter_div: radix-2 restoring divider, quotient and remainder in one result word.
// Optional macro DIV_FAST_PATH_EN: PREP skips CALC when the divisor is zero or
// |dividend| < |divisor|; results are identical, only latency changes.
//
// state | meaning
// IDLE  | accept operands, wait until both are captured
// PREP  | magnitudes, result signs, load iteration counter
// CALC  | one shift/trial-subtract per cycle, WIDTH cycles
// FIX   | apply signs, register result, pulse tvalid
module axis_iter_div #(
  parameter int WIDTH  = 32,
  parameter int SIGNED = 1
) (
  input logic           clk,
  input logic           resetn,
  axis_iter_div_if.slave bus
);
  localparam int CW  = $clog2(WIDTH);
  localparam bit SGN = (SIGNED != 0);

  typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;

  state_t             state_q, state_d;
  logic               a_cap_q, b_cap_q;
  logic [WIDTH-1:0]   a_q, b_q, b_mag_q, rem_q, quo_q;
  logic               sign_q_q, sign_r_q, div0_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] dout_q;
  logic               dout_vld_q;

  logic             a_rdy, b_rdy, hs_a, hs_b;
  logic             a_neg, b_neg, b_zero, skip;
  logic [WIDTH-1:0] a_mag, b_mag, rem_nxt, q_fix, r_fix;
  logic [WIDTH:0]   rem_sh;
  logic             ge;

  assign a_rdy = resetn & (state_q == IDLE) & ~a_cap_q;
  assign b_rdy = resetn & (state_q == IDLE) & ~b_cap_q;
  assign hs_a  = bus.s_axis_dividend_tvalid & a_rdy;
  assign hs_b  = bus.s_axis_divisor_tvalid & b_rdy;

  assign bus.s_axis_dividend_tready = a_rdy;
  assign bus.s_axis_divisor_tready  = b_rdy;
  assign bus.m_axis_dout_tdata      = dout_q;
  assign bus.m_axis_dout_tvalid     = dout_vld_q;

  // Most-negative input maps to itself, which is its correct unsigned magnitude.
  assign a_neg  = SGN & a_q[WIDTH-1];
  assign b_neg  = SGN & b_q[WIDTH-1];
  assign a_mag  = a_neg ? -a_q : a_q;
  assign b_mag  = b_neg ? -b_q : b_q;
  assign b_zero = (b_q == '0);

`ifdef DIV_FAST_PATH_EN
  assign skip = b_zero | (a_mag < b_mag);
`else
  assign skip = 1'b0;
`endif

  assign rem_sh  = {rem_q, quo_q[WIDTH-1]};
  assign ge      = (rem_sh >= {1'b0, b_mag_q});
  assign rem_nxt = ge ? WIDTH'(rem_sh - {1'b0, b_mag_q}) : rem_sh[WIDTH-1:0];

  assign q_fix = sign_q_q ? -quo_q : quo_q;
  assign r_fix = sign_r_q ? -rem_q : rem_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; a same-edge second handshake enters PREP at that edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if ((a_cap_q | hs_a) & (b_cap_q | hs_b)) state_d = PREP;
      PREP: state_d = skip ? FIX : CALC;
      CALC: if (cnt_q == '0) state_d = FIX;
      FIX:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_cap_q    <= 1'b0;
      b_cap_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      b_mag_q    <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      sign_q_q   <= 1'b0;
      sign_r_q   <= 1'b0;
      div0_q     <= 1'b0;
      cnt_q      <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      dout_vld_q <= 1'b0;
      if (hs_a) begin
        a_q     <= bus.s_axis_dividend_tdata;
        a_cap_q <= 1'b1;
      end
      if (hs_b) begin
        b_q     <= bus.s_axis_divisor_tdata;
        b_cap_q <= 1'b1;
      end
      case (state_q)
        PREP: begin
          b_mag_q  <= b_mag;
          sign_q_q <= a_neg ^ b_neg;
          sign_r_q <= a_neg;
          div0_q   <= b_zero;
          cnt_q    <= CW'(WIDTH - 1);
          if (skip) begin
            rem_q <= a_mag;
            quo_q <= '0;
          end else begin
            rem_q <= '0;
            quo_q <= a_mag;
          end
        end
        CALC: begin
          rem_q <= rem_nxt;
          quo_q <= {quo_q[WIDTH-2:0], ge};
          cnt_q <= cnt_q - 1'b1;
        end
        FIX: begin
          // Divide by zero reports all-ones quotient and the raw dividend.
          dout_q     <= div0_q ? {{WIDTH{1'b1}}, a_q} : {q_fix, r_fix};
          dout_vld_q <= 1'b1;
          a_cap_q    <= 1'b0;
          b_cap_q    <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
